// File: rtl/uart_frame_loader.sv
// rtl/uart_frame_loader.sv - sync-header detector that streams one frame of UART bytes into the BRAM write port
// Optional inter-byte timeout recovery: define UART_FRAME_TIMEOUT_EN.
module uart_frame_loader #(
  parameter int          FRAME_PIXELS   = 307200,
  parameter int          ADDR_W         = 19,
  parameter int          TIMEOUT_CYCLES = 5000000,
  parameter logic [7:0]  SYNC0          = 8'hAA,
  parameter logic [7:0]  SYNC1          = 8'h55
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              data_valid,
  input  logic [7:0]        data_out,
  output logic [7:0]        wr_data,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_en,
  output logic              loading,
  output logic              frame_done,
  output logic              frame_valid,
  output logic              timeout_err
);

  typedef enum logic [1:0] {IDLE, SYNC, LOAD, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);

  state_t            state;
  logic [ADDR_W-1:0] count;

`ifdef UART_FRAME_TIMEOUT_EN
  localparam int              GAP_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYCLES - 1);
  logic [GAP_W-1:0] gap;
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      count       <= '0;
      wr_data     <= '0;
      wr_addr     <= '0;
      wr_en       <= 1'b0;
      loading     <= 1'b0;
      frame_done  <= 1'b0;
      frame_valid <= 1'b0;
`ifdef UART_FRAME_TIMEOUT_EN
      gap         <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      wr_en      <= 1'b0;
      frame_done <= 1'b0;
`ifdef UART_FRAME_TIMEOUT_EN
      timeout_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (data_valid && data_out == SYNC0) state <= SYNC;
        end
        SYNC: begin
          if (data_valid) begin
            if (data_out == SYNC1) begin
              state       <= LOAD;
              count       <= '0;
              frame_valid <= 1'b0;
              loading     <= 1'b1;
            end else if (data_out != SYNC0) begin
              state <= IDLE;
            end
          end
        end
        LOAD: begin
          // Header values here are ordinary pixels; only the count ends the frame.
          if (data_valid) begin
            wr_en   <= 1'b1;
            wr_data <= data_out;
            wr_addr <= count;
            if (count == LAST_ADDR) begin
              count   <= '0;
              state   <= DONE;
              loading <= 1'b0;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        DONE: begin
          frame_done  <= 1'b1;
          frame_valid <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
`ifdef UART_FRAME_TIMEOUT_EN
      // Gap overrides the case only on idle cycles, so it never races a write.
      if (state == SYNC || state == LOAD) begin
        if (data_valid) begin
          gap <= '0;
        end else if (gap == GAP_LAST) begin
          gap         <= '0;
          state       <= IDLE;
          loading     <= 1'b0;
          timeout_err <= 1'b1;
        end else begin
          gap <= gap + 1'b1;
        end
      end else begin
        gap <= '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_uart_frame_loader.sv
// tb/tb_uart_frame_loader.sv - scoreboard bench for uart_frame_loader (FRAME_PIXELS=4, TIMEOUT_CYCLES=100)
module tb_uart_frame_loader;
  localparam int FP = 4;
  localparam int AW = 3;
  localparam int TO = 100;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          data_valid = 1'b0;
  logic [7:0]    data_out = 8'h00;
  logic [7:0]    wr_data;
  logic [AW-1:0] wr_addr;
  logic          wr_en;
  logic          loading;
  logic          frame_done;
  logic          frame_valid;
  logic          timeout_err;

  uart_frame_loader #(
    .FRAME_PIXELS(FP), .ADDR_W(AW), .TIMEOUT_CYCLES(TO), .SYNC0(8'hAA), .SYNC1(8'h55)
  ) dut (
    .clk(clk), .rst_n(rst_n), .data_valid(data_valid), .data_out(data_out),
    .wr_data(wr_data), .wr_addr(wr_addr), .wr_en(wr_en), .loading(loading),
    .frame_done(frame_done), .frame_valid(frame_valid), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int fd_count = 0;
  int exp_fd = 0;
  int to_count = 0;
  logic prev_wr_en = 1'b0;
  logic [AW+7:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Scoreboard: every write must match the oldest expected (addr,data).
  always @(negedge clk) begin
    logic [AW+7:0] e;
    if (wr_en) begin
      chk("write_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("wr_addr", 32'(wr_addr), 32'(e[AW+7:8]));
        chk("wr_data", 32'(wr_data), 32'(e[7:0]));
      end
    end
    if (frame_done) begin
      fd_count++;
      chk("done_after_last_write", 32'(prev_wr_en), 32'd1);
      chk("valid_with_done", 32'(frame_valid), 32'd1);
    end
    if (timeout_err) to_count++;
    prev_wr_en = wr_en;
  end

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    data_valid = 1'b1;
    data_out = b;
    @(negedge clk);
    data_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic pix(input logic [7:0] b, input int a);
    logic [AW-1:0] av;
    av = a[AW-1:0];
    exp_q.push_back({av, b});
    send(b);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_wr_en"}, 32'(wr_en), 32'd0);
    chk({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
    chk({tag, "_wr_data"}, 32'(wr_data), 32'd0);
    chk({tag, "_loading"}, 32'(loading), 32'd0);
    chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    chk({tag, "_frame_valid"}, 32'(frame_valid), 32'd0);
    chk({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_to;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;

    // Broken header: nothing written
    send(8'hAA); send(8'h12); send(8'h55); send(8'h01);
    repeat (5) @(negedge clk);
    chk("badhdr_frame_valid", 32'(frame_valid), 32'd0);
    chk("badhdr_loading", 32'(loading), 32'd0);

    // Basic frame
    send(8'hAA); send(8'h55);
    chk("basic_loading", 32'(loading), 32'd1);
    pix(8'h11, 0); pix(8'h22, 1); pix(8'h33, 2); pix(8'h44, 3);
    exp_fd++;
    chk("basic_fd_count", 32'(fd_count), 32'(exp_fd));
    chk("basic_frame_valid", 32'(frame_valid), 32'd1);
    chk("basic_loading_off", 32'(loading), 32'd0);

    // New header invalidates the held frame
    send(8'hAA);
    chk("reload_valid_before", 32'(frame_valid), 32'd1);
    send(8'h55);
    chk("reload_valid_cleared", 32'(frame_valid), 32'd0);
    pix(8'h77, 0);
    chk("reload_loading", 32'(loading), 32'd1);
    pix(8'hAA, 1); pix(8'h55, 2); pix(8'h7A, 3);
    exp_fd++;
    chk("reload_fd_count", 32'(fd_count), 32'(exp_fd));

    // Repeated AA in SYNC
    send(8'hAA); send(8'hAA); send(8'h55);
    pix(8'h01, 0); pix(8'h02, 1); pix(8'h03, 2); pix(8'h04, 3);
    exp_fd++;
    chk("repaa_fd_count", 32'(fd_count), 32'(exp_fd));

    // Byte landing in the DONE cycle is dropped
    send(8'hAA); send(8'h55);
    pix(8'h05, 0); pix(8'h06, 1); pix(8'h07, 2);
    exp_q.push_back({3'(3), 8'h08});
    @(negedge clk); data_valid = 1'b1; data_out = 8'h08;
    @(negedge clk); data_out = 8'hAA;
    @(negedge clk); data_valid = 1'b0;
    repeat (3) @(negedge clk);
    send(8'h55); send(8'h01);
    repeat (5) @(negedge clk);
    exp_fd++;
    chk("dropped_fd_count", 32'(fd_count), 32'(exp_fd));
    chk("dropped_loading", 32'(loading), 32'd0);

    // Truncated transfer
    send(8'hAA); send(8'h55);
    pix(8'h01, 0); pix(8'h02, 1);
    first_to = -1;
    for (int i = 0; i < 130; i++) begin
      @(negedge clk);
      if (timeout_err && first_to < 0) first_to = i;
    end
`ifdef UART_FRAME_TIMEOUT_EN
    chk("to_pulse_count", 32'(to_count), 32'd1);
    chk("to_not_early", 32'(first_to >= 90), 32'd1);
    chk("to_not_late", 32'(first_to <= 100), 32'd1);
    chk("to_loading", 32'(loading), 32'd0);
    chk("to_frame_valid", 32'(frame_valid), 32'd0);
    send(8'hAA); send(8'h55);
    pix(8'h0A, 0); pix(8'h0B, 1); pix(8'h0C, 2); pix(8'h0D, 3);
`else
    chk("noto_pulse_count", 32'(to_count), 32'd0);
    chk("noto_loading", 32'(loading), 32'd1);
    pix(8'h03, 2); pix(8'h04, 3);
`endif
    exp_fd++;
    chk("after_gap_fd_count", 32'(fd_count), 32'(exp_fd));

    // Reset mid-load
    send(8'hAA); send(8'h55);
    pix(8'h21, 0); pix(8'h22, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero("midreset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send(8'hAA); send(8'h55);
    pix(8'h31, 0);
    chk("postreset_loading", 32'(loading), 32'd1);
    pix(8'h32, 1); pix(8'h33, 2); pix(8'h34, 3);
    exp_fd++;
    chk("postreset_fd_count", 32'(fd_count), 32'(exp_fd));
    chk("postreset_frame_valid", 32'(frame_valid), 32'd1);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_frame_loader.md
# uart_frame_loader

Sequencing controller between `uart_rx` and the `ram_2port` frame buffer. It consumes the byte stream from the UART receiver (`data_valid`/`data_out`), waits for a two-byte sync header, then writes exactly one frame of pixel bytes into the BRAM write port at sequential addresses. It signals frame completion and validity to the VGA read side. With the timeout feature compiled in, it recovers from a truncated transfer.

## Interface
- `FRAME_PIXELS`, 307200: bytes per frame (640×480, one byte per pixel).
- `ADDR_W`, 19: BRAM address width; must satisfy 2^ADDR_W ≥ FRAME_PIXELS.
- `TIMEOUT_CYCLES`, 5000000: inter-byte gap in clk cycles (100 ms at 50 MHz) that aborts a load.
- `SYNC0`, 8'hAA: first header byte.
- `SYNC1`, 8'h55: second header byte.

Ports:
- `clk`  in  1  system clock, 50 MHz.
- `rst_n`  in  1  asynchronous, active-low reset.
- `data_valid`  in  1  one-cycle strobe from `uart_rx`: a byte is available.
- `data_out`  in  8  received byte, valid while `data_valid`=1.
- `wr_data`  out  8  BRAM `data`.
- `wr_addr`  out  ADDR_W  BRAM `wraddress`.
- `wr_en`  out  1  BRAM `wren`.
- `loading`  out  1  high while in LOAD.
- `frame_done`  out  1  one-cycle pulse when the last pixel of a frame has been written.
- `frame_valid`  out  1  high while the buffer holds a complete frame.
- `timeout_err`  out  1  one-cycle pulse when a load is aborted.

## Operation
- FSM states: IDLE, SYNC, LOAD, DONE.
- IDLE
  - `data_valid` with byte = SYNC0 → SYNC.
  - Any other byte is ignored.
- SYNC
  - Byte = SYNC1 → LOAD; the pixel counter clears to 0 and `frame_valid` clears.
  - Byte = SYNC0 → stay in SYNC (handles a repeated 0xAA).
  - Any other byte → IDLE.
- LOAD
  - Each `data_valid` produces one write: `wr_data`=byte, `wr_addr`=counter, `wr_en`=1. The counter then increments.
  - The write of address FRAME_PIXELS-1 → DONE.
  - Header bytes inside LOAD are pixel data, not resync.
- DONE
  - Lasts one cycle: `frame_done`=1, `frame_valid` set, → IDLE.
- Counter arithmetic
  - The counter is ADDR_W bits and never exceeds FRAME_PIXELS-1.
  - It is never wrapped modulo 2^ADDR_W.
- Byte arriving in the DONE cycle: `uart_rx` cannot emit bytes that close together (minimum 10 bit times), so none is expected. If one does arrive, it is dropped.
- Reset mid-load
  - All state clears and the FSM returns to IDLE.
  - BRAM contents are untouched; `frame_valid`=0 marks them stale.

## Timing
- Reset values:
  - `wr_en`, `wr_addr`, `wr_data` = 0.
  - `loading`, `frame_done`, `frame_valid`, `timeout_err` = 0.
  - State = IDLE; counter = 0.
- All outputs are registered.
- Write latency: `wr_en` is asserted the cycle after `data_valid`, for exactly one cycle, with `wr_addr`/`wr_data` stable in that cycle.
- `frame_done` asserts one cycle after the final `wr_en`.
- `frame_valid` rises in the same cycle as `frame_done`. It falls in the cycle after SYNC1 is accepted.
- `loading` rises on entry to LOAD and falls on exit.
- Throughput: one write per `data_valid`. No backpressure; the BRAM always accepts.

## Configuration
- `UART_FRAME_TIMEOUT_EN` defined:
  - In SYNC and LOAD, a gap counter resets on each `data_valid`.
  - When the gap reaches TIMEOUT_CYCLES, the FSM goes → IDLE and `timeout_err` pulses for one cycle.
  - The partial frame leaves `frame_valid`=0.
- Not defined:
  - There is no gap counter, and `timeout_err` is tied to 0.
  - SYNC and LOAD wait indefinitely.

## Test plan
Benches use FRAME_PIXELS=4 and TIMEOUT_CYCLES=100, and drive `data_valid` strobes directly.

- Send AA 55 11 22 33 44 → writes (0,11) (1,22) (2,33) (3,44); `frame_done` pulses once, one cycle after the last write; `frame_valid`=1.
- Send AA AA 55 01 02 03 04 → SYNC persists through the repeated AA; the frame loads normally at addresses 0–3.
- Send AA 12 55 01 → no writes occur (AA 12 returns to IDLE; 55 and 01 are ignored); `frame_valid` stays 0.
- Load one frame, then send AA 55 77 → `frame_valid` falls after the 55; address 0 is written with 77; `loading`=1.
- With `UART_FRAME_TIMEOUT_EN`: send AA 55 01 02, then idle 100 cycles → `timeout_err` pulses, state returns to IDLE, and a following AA 55 restarts at address 0.
- Assert `rst_n`=0 after two pixel writes → all outputs are 0 immediately; after release, the next frame starts at address 0.
